fetch_seq_ctrl: RTL and testbench

- Fetch-stage sequencer for the two-stage RV32 pipe. Owns the fetch PC and issues instruction-memory requests.
- Holds a response while decode is stalled and applies branch/jump redirects from execute.
- Drives pc_i, instruct_in and flush of the IF/ID pipeline register, so every IF/ID load is either a real instruction or a NOP bubble.

---
 rtl/fetch_pkg.sv | 6 +
 rtl/fetch_hold_buf.sv | 28 ++
 rtl/fetch_seq_ctrl.sv | 99 +++++++++
 tb/tb_fetch_seq_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the fetch sequencer
package fetch_pkg;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DISCARD, ERR} fetch_state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0033;
  localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: one-entry pc/instruction buffer that keeps a response while decode stalls
module fetch_hold_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);
  // clear wins over load so a redirect always empties the buffer
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= NOP_INSTR;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= pc_in;
      instr <= instr_in;
    end
endmodule

// File: rtl/fetch_seq_ctrl.sv
// fetch_seq_ctrl: fetch-stage sequencer driving imem requests and the IF/ID register inputs
module fetch_seq_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_instr,
  output logic        flush,
  output logic        fetch_valid,
  output logic        fetch_err
);
  fetch_state_t state, state_d;
  logic [31:0] pc_q, last_pc, last_instr, buf_pc, buf_instr;
  logic [8:0]  cnt;
  logic        buf_valid, in_err, redir, got, take, timeout;

  assign in_err  = state == ERR;
  assign redir   = redirect_valid && !in_err;
  assign got     = state == WAIT && imem_rvalid && !redir;
  assign take    = (got || state == HOLD) && !id_stall && !redir;
  assign timeout = cnt >= 9'(MAX_WAIT);

  fetch_hold_buf u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (got && id_stall),
    .clear    (redir || take),
    .pc_in    (pc_q),
    .instr_in (imem_rdata),
    .valid    (buf_valid),
    .pc       (buf_pc),
    .instr    (buf_instr)
  );

  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_d;

  // next state: redirect outranks everything but ERR; an issued request must be drained in DISCARD
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = REQ;
      REQ:     state_d = redir ? DISCARD : WAIT;
      WAIT:    state_d = redir ? (imem_rvalid ? REQ : DISCARD)
                       : imem_rvalid ? (id_stall ? HOLD : REQ)
                       : timeout ? ERR : WAIT;
      HOLD:    state_d = (redir || !id_stall) ? REQ : HOLD;
      DISCARD: state_d = imem_rvalid ? REQ : (timeout && !redir) ? ERR : DISCARD;
      default: state_d = ERR;
    endcase
  end

  // fetch pc, response wait counter, and a copy of what IF/ID currently holds
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc_q       <= RESET_PC;
      cnt        <= '0;
      last_pc    <= RESET_PC;
      last_instr <= NOP_INSTR;
    end else begin
      pc_q       <= redir ? (redirect_pc & ~32'd3) : take ? pc_q + PC_STEP : pc_q;
      cnt        <= state == REQ ? 9'd1
                  : ((state == WAIT || state == DISCARD) && !imem_rvalid) ? cnt + 9'd1 : cnt;
      last_pc    <= flush ? fetch_pc - PC_STEP : fetch_pc;
      last_instr <= flush ? NOP_INSTR : fetch_instr;
    end

  // outputs: bubble by default (IF/ID stores pc_i-4 on flush, so pc_q+4 lands as pc_q)
  always_comb begin
    imem_req    = rst && state == REQ;
    imem_addr   = pc_q;
    fetch_err   = rst && in_err;
    flush       = 1'b1;
    fetch_valid = 1'b0;
    fetch_pc    = rst ? pc_q + PC_STEP : RESET_PC + PC_STEP;
    fetch_instr = NOP_INSTR;
    if (rst && !in_err && !redir) begin
      if (state == WAIT && imem_rvalid)
        {flush, fetch_valid, fetch_pc, fetch_instr} = {2'b01, pc_q, imem_rdata};
      else if (state == HOLD)
        {flush, fetch_valid, fetch_pc, fetch_instr} = {1'b0, buf_valid, buf_pc, buf_instr};
      else if (id_stall)
        {flush, fetch_valid, fetch_pc, fetch_instr} = {2'b00, last_pc, last_instr};
    end
  end
endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// tb_fetch_seq_ctrl: directed stimulus with a scoreboard monitor for fetch_seq_ctrl
module tb_fetch_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req, imem_rvalid = 1'b0, redirect_valid = 1'b0, id_stall = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0, redirect_pc = '0;
  logic [31:0] fetch_pc, fetch_instr;
  logic        flush, fetch_valid, fetch_err;
  int          passed = 0, total = 0;
  logic [31:0] exp_addr[$], exp_pc[$], exp_ins[$];

  fetch_seq_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .fetch_pc       (fetch_pc),
    .fetch_instr    (fetch_instr),
    .flush          (flush),
    .fetch_valid    (fetch_valid),
    .fetch_err      (fetch_err)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    total++;
    $display("FAIL %s: got %h with nothing expected", name, act);
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a << 20) | 32'h0000_0093;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 40) begin
      tick();
      n++;
    end
    if (!imem_req) fail("req_timeout", {31'd0, imem_req});
  endtask

  task automatic respond(input int lat, input logic [31:0] d);
    repeat (lat) tick();
    imem_rvalid = 1'b1;
    imem_rdata  = d;
  endtask

  task automatic push_fetch(input logic [31:0] pc, input logic [31:0] ins);
    exp_pc.push_back(pc);
    exp_ins.push_back(ins);
  endtask

  // monitor: pops expectations whenever a request or a delivery appears
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (imem_req) begin
        if (exp_addr.size() == 0) fail("addr_unexpected", imem_addr);
        else chk("imem_addr", imem_addr, exp_addr.pop_front());
      end
      if (fetch_valid && !id_stall) begin
        if (exp_pc.size() == 0) fail("fetch_unexpected", fetch_pc);
        else begin
          chk("fetch_pc", fetch_pc, exp_pc.pop_front());
          chk("fetch_instr", fetch_instr, exp_ins.pop_front());
        end
      end
      if (fetch_valid && fetch_instr == 32'hDEAD_BEEF) fail("dropped_resp_seen", fetch_instr);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) tick();
    @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 0);
    chk("rst_valid", {31'd0, fetch_valid}, 0);
    chk("rst_err", {31'd0, fetch_err}, 0);
    chk("rst_flush", {31'd0, flush}, 1);
    chk("rst_pc", fetch_pc, 32'h4);
    chk("rst_instr", fetch_instr, 32'h33);
    tick();
    rst = 1'b1;
    // straight-line fetch, 1-cycle memory
    exp_addr.push_back(32'h0);
    wait_req();
    @(negedge clk);
    chk("req_flush", {31'd0, flush}, 1);
    chk("req_bubble_valid", {31'd0, fetch_valid}, 0);
    push_fetch(32'h0, mem(32'h0));
    respond(1, mem(32'h0));
    tick();
    imem_rvalid = 1'b0;
    // response at pc 4 under a 3-cycle stall
    exp_addr.push_back(32'h4);
    wait_req();
    respond(1, 32'h0050_0093);
    id_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_instr", fetch_instr, 32'h0050_0093);
      chk("stall_pc", fetch_pc, 32'h4);
      chk("stall_flush", {31'd0, flush}, 0);
      chk("stall_no_req", {31'd0, imem_req}, 0);
      tick();
      imem_rvalid = 1'b0;
    end
    push_fetch(32'h4, 32'h0050_0093);
    exp_addr.push_back(32'h8);
    id_stall = 1'b0;
    tick();
    wait_req();
    push_fetch(32'h8, mem(32'h8));
    respond(2, mem(32'h8));
    tick();
    imem_rvalid = 1'b0;
    // redirect during WAIT, late response dropped
    exp_addr.push_back(32'hC);
    wait_req();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    chk("redir_flush", {31'd0, flush}, 1);
    chk("redir_valid", {31'd0, fetch_valid}, 0);
    tick();
    redirect_valid = 1'b0;
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("discard_flush", {31'd0, flush}, 1);
    chk("discard_pc", fetch_pc, 32'h104);
    exp_addr.push_back(32'h100);
    tick();
    imem_rvalid = 1'b0;
    // redirect coincident with the response, unaligned target
    wait_req();
    tick();
    imem_rvalid    = 1'b1;
    imem_rdata     = mem(32'h100);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    @(negedge clk);
    chk("coinc_flush", {31'd0, flush}, 1);
    chk("coinc_valid", {31'd0, fetch_valid}, 0);
    exp_addr.push_back(32'h200);
    tick();
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    wait_req();
    push_fetch(32'h200, mem(32'h200));
    respond(1, mem(32'h200));
    tick();
    imem_rvalid = 1'b0;
    // reset mid-WAIT
    exp_addr.push_back(32'h204);
    wait_req();
    tick();
    rst = 1'b0;
    #1;
    chk("rstw_req", {31'd0, imem_req}, 0);
    chk("rstw_flush", {31'd0, flush}, 1);
    chk("rstw_pc", fetch_pc, 32'h4);
    chk("rstw_valid", {31'd0, fetch_valid}, 0);
    exp_addr.push_back(32'h0);
    tick();
    rst = 1'b1;
    // reset while holding
    wait_req();
    respond(1, mem(32'h0));
    id_stall = 1'b1;
    tick();
    imem_rvalid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rsth_valid", {31'd0, fetch_valid}, 0);
    chk("rsth_instr", fetch_instr, 32'h33);
    chk("rsth_flush", {31'd0, flush}, 1);
    id_stall = 1'b0;
    exp_addr.push_back(32'h0);
    tick();
    rst = 1'b1;
    wait_req();
    push_fetch(32'h0, mem(32'h0));
    respond(1, mem(32'h0));
    tick();
    imem_rvalid = 1'b0;
    // response timeout
    exp_addr.push_back(32'h4);
    wait_req();
    repeat (15) tick();
    @(negedge clk);
    chk("to_err_c15", {31'd0, fetch_err}, 0);
    tick();
    @(negedge clk);
    chk("to_err_c16", {31'd0, fetch_err}, 1);
    chk("to_flush", {31'd0, flush}, 1);
    chk("to_req", {31'd0, imem_req}, 0);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("err_sticky", {31'd0, fetch_err}, 1);
    chk("err_flush", {31'd0, flush}, 1);
    rst = 1'b0;
    #1;
    chk("err_cleared", {31'd0, fetch_err}, 0);
    chk("addr_q_empty", exp_addr.size(), 0);
    chk("fetch_q_empty", exp_pc.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
